// File: rtl/uart_rx_deser_param.sv
// UART RX deserializer: shifts DATA_WIDTH sampled bits into a parallel word
// with selectable bit order, running even parity and a one-cycle valid pulse.
module uart_rx_deser_param #(
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  serial_data,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_parity,
   output logic                  data_valid,
   output logic [3:0]            bit_count
);

   localparam logic [3:0] LAST = 4'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] sr, sr_next;
   logic [3:0]            cnt;
   logic                  rp, rp_next;

   generate
      if (MSB_FIRST) begin : g_msb
         assign sr_next = {sr[DATA_WIDTH-2:0], serial_data};
      end else begin : g_lsb
         assign sr_next = {serial_data, sr[DATA_WIDTH-1:1]};
      end
   endgenerate

   assign rp_next   = rp ^ serial_data;
   assign bit_count = cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr          <= '0;
         cnt         <= '0;
         rp          <= 1'b0;
         p_data      <= '0;
         data_parity <= 1'b0;
         data_valid  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (clear) begin
            // abort drops the partial word but keeps the last completed one
            sr  <= '0;
            cnt <= '0;
            rp  <= 1'b0;
         end else if (enable) begin
            sr <= sr_next;
            if (cnt == LAST) begin
               p_data      <= sr_next;
               data_parity <= rp_next;
               data_valid  <= 1'b1;
               cnt         <= '0;
               rp          <= 1'b0;
            end else begin
               rp  <= rp_next;
               cnt <= cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Bench for uart_rx_deser_param: three instances (8b LSB, 8b MSB, 7b LSB)
// share one stimulus stream and are checked each cycle against a word-level model.
module tb_uart_rx_deser_param;

   logic clk = 1'b0;
   logic rst, enable, serial_data, clear;

   logic [7:0] pd0, pd1;
   logic [6:0] pd2;
   logic       par0, par1, par2, dv0, dv1, dv2;
   logic [3:0] bc0, bc1, bc2;

   int checks = 0;
   int failures = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   uart_rx_deser_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u0 (
      .clk(clk), .rst(rst), .enable(enable), .serial_data(serial_data), .clear(clear),
      .p_data(pd0), .data_parity(par0), .data_valid(dv0), .bit_count(bc0));
   uart_rx_deser_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u1 (
      .clk(clk), .rst(rst), .enable(enable), .serial_data(serial_data), .clear(clear),
      .p_data(pd1), .data_parity(par1), .data_valid(dv1), .bit_count(bc1));
   uart_rx_deser_param #(.DATA_WIDTH(7), .MSB_FIRST(1'b0)) u2 (
      .clk(clk), .rst(rst), .enable(enable), .serial_data(serial_data), .clear(clear),
      .p_data(pd2), .data_parity(par2), .data_valid(dv2), .bit_count(bc2));

   // Model: collect bits of the current word in arrival order, build the word
   // only when it is complete.
   int W[3]   = '{8, 8, 7};
   bit MSB[3] = '{1'b0, 1'b1, 1'b0};
   bit bits_m[3][9];
   int cnt_m[3], pd_m[3];
   bit par_m[3], dv_m[3];

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            cnt_m[k] = 0; pd_m[k] = 0; par_m[k] = 0; dv_m[k] = 0;
         end else if (clear) begin
            cnt_m[k] = 0; dv_m[k] = 0;
         end else if (enable) begin
            bits_m[k][cnt_m[k]] = serial_data;
            cnt_m[k]++;
            dv_m[k] = 0;
            if (cnt_m[k] == W[k]) begin
               pd_m[k] = 0; par_m[k] = 0;
               for (int i = 0; i < W[k]; i++) begin
                  if (bits_m[k][i]) begin
                     pd_m[k] += (MSB[k] ? (1 << (W[k]-1-i)) : (1 << i));
                     par_m[k] = ~par_m[k];
                  end
               end
               dv_m[k] = 1; cnt_m[k] = 0;
            end
         end else begin
            dv_m[k] = 0;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic cmp(input int k, input int pd, input bit par, input bit dv, input int bc);
      chk($sformatf("u%0d.p_data", k), pd, pd_m[k]);
      chk($sformatf("u%0d.data_parity", k), int'(par), int'(par_m[k]));
      chk($sformatf("u%0d.data_valid", k), int'(dv), int'(dv_m[k]));
      chk($sformatf("u%0d.bit_count", k), bc, cnt_m[k]);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         cmp(0, int'(pd0), par0, dv0, int'(bc0));
         cmp(1, int'(pd1), par1, dv1, int'(bc1));
         cmp(2, int'(pd2), par2, dv2, int'(bc2));
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send_bit(input bit b);
      enable = 1'b1; serial_data = b;
      step();
   endtask

   task automatic idle(input int n);
      enable = 1'b0; serial_data = 1'b0;
      repeat (n) step();
   endtask

   // Bits go out in the order w[0], w[1], ...; gap idle cycles between bits only.
   task automatic send_word(input logic [8:0] w, input int n, input int gap);
      logic [8:0] v;
      v = w;
      for (int i = 0; i < n; i++) begin
         send_bit(v[i]);
         if (gap > 0 && i < n-1) idle(gap);
      end
   endtask

   task automatic do_clear();
      enable = 1'b0; clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; serial_data = 1'b0; clear = 1'b0;
      step();
      chk_on = 1'b1;
      step();
      chk("reset.p_data", int'(pd0), 0);
      chk("reset.bit_count", int'(bc0), 0);
      rst = 1'b0;
      idle(2);

      // LSB-first 1,0,1,0,0,1,0,1 -> 0xA5; MSB-first reads the same pattern
      send_word(9'h0A5, 8, 0);
      chk("lsb.p_data", int'(pd0), 'hA5);
      chk("lsb.parity", int'(par0), 0);
      chk("lsb.valid", int'(dv0), 1);
      chk("lsb.bit_count", int'(bc0), 0);
      chk("msb.p_data_a5", int'(pd1), 'hA5);
      idle(1);
      chk("lsb.valid_drop", int'(dv0), 0);

      // stream 1,1,0,0,0,0,0,1
      do_clear();
      send_word(9'h083, 8, 0);
      chk("msb.p_data_c1", int'(pd1), 'hC1);
      chk("msb.parity_c1", int'(par1), 1);
      chk("lsb.p_data_83", int'(pd0), 'h83);
      idle(1);

      // gapped 0x3C then 0xFF straight after
      do_clear();
      send_word(9'h03C, 8, 15);
      chk("gap.p_data_3c", int'(pd0), 'h3C);
      chk("gap.parity_3c", int'(par0), 0);
      chk("gap.valid_3c", int'(dv0), 1);
      send_word(9'h0FF, 8, 0);
      chk("b2b.p_data_ff", int'(pd0), 'hFF);
      chk("b2b.parity_ff", int'(par0), 0);
      chk("b2b.valid_ff", int'(dv0), 1);
      idle(1);

      // clear with enable after 4 bits
      do_clear();
      send_word(9'h00F, 4, 0);
      chk("clr.bit_count_4", int'(bc0), 4);
      enable = 1'b1; serial_data = 1'b1; clear = 1'b1;
      step();
      clear = 1'b0; enable = 1'b0;
      chk("clr.bit_count", int'(bc0), 0);
      chk("clr.valid", int'(dv0), 0);
      chk("clr.p_data_hold", int'(pd0), 'hFF);
      idle(2);
      send_word(9'h05A, 8, 0);
      chk("clr.p_data_5a", int'(pd0), 'h5A);
      idle(1);

      // reset mid-word
      do_clear();
      send_word(9'h01F, 5, 0);
      enable = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0; enable = 1'b0;
      chk("rst.p_data", int'(pd0), 0);
      chk("rst.parity", int'(par0), 0);
      chk("rst.bit_count", int'(bc0), 0);
      idle(1);
      send_word(9'h081, 8, 0);
      chk("rst.p_data_81", int'(pd0), 'h81);
      idle(1);

      // 7-bit instance: 0x55
      do_clear();
      send_word(9'h015, 6, 0);
      chk("w7.bit_count_6", int'(bc2), 6);
      send_bit(1'b1);
      chk("w7.p_data", int'(pd2), 'h55);
      chk("w7.parity", int'(par2), 0);
      chk("w7.valid", int'(dv2), 1);
      chk("w7.bit_count_wrap", int'(bc2), 0);
      idle(3);

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
